traffic_ctrl_param: RTL and testbench

Parametrised two-direction intersection controller, the next generation of the fixed-timing traffic light block. It generates lamp outputs for directions 1 and 2 and a two-digit countdown display per direction. Phase durations and the tick prescaler are parameters, and it adds a night mode with flashing yellow. It sits at board top level, driven by the board oscillator, and feeds LEDs and common-anode 7-segment digits directly.

---
 rtl/traffic_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 18 +
 rtl/traffic_ctrl_param.sv | 133 +++++++++++++
 tb/tb_traffic_ctrl_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the parametrised intersection controller:
// phase enum, blank code and the active-low 7-segment digit patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    G1R2,
    Y1R2,
    RR_A,
    R1G2,
    R1Y2,
    RR_B,
    NIGHT
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds digit n, segments {g..a}, a lit segment is 0.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic state_t next_phase(input state_t s);
    case (s)
      G1R2:    next_phase = Y1R2;
      Y1R2:    next_phase = RR_A;
      RR_A:    next_phase = R1G2;
      R1G2:    next_phase = R1Y2;
      R1Y2:    next_phase = RR_B;
      default: next_phase = G1R2;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes and the
// blank request both produce a dark digit.
module seg7_decode
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_DIGITS[bcd];
    end
  end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Two-direction traffic light controller with parametrised phase lengths,
// per-direction two-digit countdown and a flashing-yellow night mode.
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       night_mode,
  output logic       R1,
  output logic       Y1,
  output logic       G1,
  output logic       R2,
  output logic       Y2,
  output logic       G2,
  output logic [6:0] D1Seg0,
  output logic [6:0] D1Seg1,
  output logic [6:0] D2Seg0,
  output logic [6:0] D2Seg1
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [6:0] TG = 7'(T_GREEN);
  localparam logic [6:0] TY = 7'(T_YELLOW);
  localparam logic [6:0] TA = 7'(T_ALLRED);

  if ((TICK_DIV < 2) || (T_GREEN < 1) || (T_YELLOW < 1) || (T_ALLRED < 1) ||
      ((T_GREEN + T_YELLOW + T_ALLRED) > 99)) begin : g_param_check
    $error("traffic_ctrl_param: illegal timing parameters");
  end

  logic [CW-1:0] cnt;
  logic          tick;
  state_t        state_q, state_d;
  logic [6:0]    timer_q, timer_d;
  logic          flash_q, flash_d;
  logic [6:0]    d1val, d2val;
  logic          dark;
  logic [3:0]    d1tens, d1units, d2tens, d2units;

  function automatic logic [6:0] duration(input state_t s);
    case (s)
      G1R2, R1G2: duration = TG;
      Y1R2, R1Y2: duration = TY;
      default:    duration = TA;
    endcase
  endfunction

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= G1R2;
      timer_q <= TG;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flash_q <= flash_d;
    end
  end

  // A night request outranks phase expiry when both land on the same tick.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flash_d = flash_q;
    if (tick) begin
      if ((state_q != NIGHT) && night_mode) begin
        state_d = NIGHT;
        flash_d = 1'b1;
      end else if (state_q == NIGHT) begin
        if (night_mode) begin
          flash_d = ~flash_q;
        end else begin
          state_d = RR_B;
          timer_d = TA;
          flash_d = 1'b0;
        end
      end else if (timer_q > 7'd1) begin
        timer_d = timer_q - 7'd1;
      end else begin
        state_d = next_phase(state_q);
        timer_d = duration(next_phase(state_q));
      end
    end
  end

  // The red direction counts down to its own green, so it adds the phases
  // still ahead of it.
  always_comb begin
    R1 = 1'b0; Y1 = 1'b0; G1 = 1'b0;
    R2 = 1'b0; Y2 = 1'b0; G2 = 1'b0;
    d1val = timer_q;
    d2val = timer_q;
    dark  = 1'b0;
    case (state_q)
      G1R2: begin G1 = 1'b1; R2 = 1'b1; d2val = timer_q + TY + TA; end
      Y1R2: begin Y1 = 1'b1; R2 = 1'b1; d2val = timer_q + TA; end
      RR_A, RR_B: begin R1 = 1'b1; R2 = 1'b1; end
      R1G2: begin R1 = 1'b1; G2 = 1'b1; d1val = timer_q + TY + TA; end
      R1Y2: begin R1 = 1'b1; Y2 = 1'b1; d1val = timer_q + TA; end
      NIGHT: begin Y1 = flash_q; Y2 = flash_q; dark = 1'b1; end
      default: begin end
    endcase
  end

  assign d1tens  = 4'(d1val / 7'd10);
  assign d1units = 4'(d1val % 7'd10);
  assign d2tens  = 4'(d2val / 7'd10);
  assign d2units = 4'(d2val % 7'd10);

  seg7_decode u_d1_units (.bcd(d1units), .blank(dark), .seg(D1Seg0));
  seg7_decode u_d1_tens  (.bcd(d1tens), .blank(dark || (d1tens == 4'd0)), .seg(D1Seg1));
  seg7_decode u_d2_units (.bcd(d2units), .blank(dark), .seg(D2Seg0));
  seg7_decode u_d2_tens  (.bcd(d2tens), .blank(dark || (d2tens == 4'd0)), .seg(D2Seg1));

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed, table-driven bench for traffic_ctrl_param with short timings,
// plus a second instance with a longer green for two-digit displays.
module tb_traffic_ctrl_param;

  localparam logic [5:0] L_G1R2 = 6'b001100;
  localparam logic [5:0] L_Y1R2 = 6'b010100;
  localparam logic [5:0] L_RR   = 6'b100100;
  localparam logic [5:0] L_R1G2 = 6'b100001;
  localparam logic [5:0] L_R1Y2 = 6'b100010;
  localparam logic [5:0] L_NY   = 6'b010010;
  localparam logic [5:0] L_OFF  = 6'b000000;

  typedef struct {
    logic       night;
    logic [5:0] lamps;
    int         d1;
    int         d2;
    logic       dark;
    logic       chk12;
    int         d1b;
    int         d2b;
  } vec_t;

  logic clock;
  logic rst;
  logic night_mode;
  logic R1, Y1, G1, R2, Y2, G2;
  logic [6:0] D1Seg0, D1Seg1, D2Seg0, D2Seg1;
  logic bR1, bY1, bG1, bR2, bY2, bG2;
  logic [6:0] bD1Seg0, bD1Seg1, bD2Seg0, bD2Seg1;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  traffic_ctrl_param #(.TICK_DIV(4), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1)) dut (
    .clock(clock), .rst(rst), .night_mode(night_mode),
    .R1(R1), .Y1(Y1), .G1(G1), .R2(R2), .Y2(Y2), .G2(G2),
    .D1Seg0(D1Seg0), .D1Seg1(D1Seg1), .D2Seg0(D2Seg0), .D2Seg1(D2Seg1)
  );

  traffic_ctrl_param #(.TICK_DIV(4), .T_GREEN(12), .T_YELLOW(2), .T_ALLRED(1)) dut12 (
    .clock(clock), .rst(rst), .night_mode(night_mode),
    .R1(bR1), .Y1(bY1), .G1(bG1), .R2(bR2), .Y2(bY2), .G2(bG2),
    .D1Seg0(bD1Seg0), .D1Seg1(bD1Seg1), .D2Seg0(bD2Seg0), .D2Seg1(bD2Seg1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] digitPattern(input int d);
    case (d)
      0: digitPattern = 7'h40;
      1: digitPattern = 7'h79;
      2: digitPattern = 7'h24;
      3: digitPattern = 7'h30;
      4: digitPattern = 7'h19;
      5: digitPattern = 7'h12;
      6: digitPattern = 7'h02;
      7: digitPattern = 7'h78;
      8: digitPattern = 7'h00;
      default: digitPattern = 7'h10;
    endcase
  endfunction

  // {tens, units} as the two digits should look for a displayed value.
  function automatic logic [13:0] expSegs(input int v, input logic dk);
    logic [6:0] t, u;
    if (dk) begin
      t = 7'h7F;
      u = 7'h7F;
    end else begin
      t = (v / 10 == 0) ? 7'h7F : digitPattern(v / 10);
      u = digitPattern(v % 10);
    end
    return {t, u};
  endfunction

  task automatic compare(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] lamps, input int d1,
                             input int d2, input logic dk);
    compare({tag, " lamps"}, {8'h00, R1, Y1, G1, R2, Y2, G2}, {8'h00, lamps});
    compare({tag, " d1"}, {D1Seg1, D1Seg0}, expSegs(d1, dk));
    compare({tag, " d2"}, {D2Seg1, D2Seg0}, expSegs(d2, dk));
  endtask

  task automatic applyStimulus(input logic night);
    night_mode = night;
    repeat (4) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic addRow(input logic n, input logic [5:0] l, input int d1, input int d2,
                        input logic dk, input logic c12, input int d1b, input int d2b);
    vec_t v;
    v.night = n; v.lamps = l; v.d1 = d1; v.d2 = d2; v.dark = dk;
    v.chk12 = c12; v.d1b = d1b; v.d2b = d2b;
    vecs.push_back(v);
  endtask

  initial begin
    // one full normal cycle
    addRow(0, L_G1R2, 4, 7, 0, 1, 11, 14);
    addRow(0, L_G1R2, 3, 6, 0, 1, 10, 13);
    addRow(0, L_G1R2, 2, 5, 0, 1, 9, 12);
    addRow(0, L_G1R2, 1, 4, 0, 1, 8, 11);
    addRow(0, L_Y1R2, 2, 3, 0, 1, 7, 10);
    addRow(0, L_Y1R2, 1, 2, 0, 1, 6, 9);
    addRow(0, L_RR,   1, 1, 0, 1, 5, 8);
    addRow(0, L_R1G2, 8, 5, 0, 1, 4, 7);
    addRow(0, L_R1G2, 7, 4, 0, 1, 3, 6);
    addRow(0, L_R1G2, 6, 3, 0, 1, 2, 5);
    addRow(0, L_R1G2, 5, 2, 0, 1, 1, 4);
    addRow(0, L_R1G2, 4, 1, 0, 0, 0, 0);
    addRow(0, L_R1Y2, 3, 2, 0, 0, 0, 0);
    addRow(0, L_R1Y2, 2, 1, 0, 0, 0, 0);
    addRow(0, L_RR,   1, 1, 0, 0, 0, 0);
    addRow(0, L_G1R2, 5, 8, 0, 0, 0, 0);
    // night entry mid-green, flashing, exit through RR_B
    addRow(1, L_NY,   0, 0, 1, 0, 0, 0);
    addRow(1, L_OFF,  0, 0, 1, 0, 0, 0);
    addRow(1, L_NY,   0, 0, 1, 0, 0, 0);
    addRow(0, L_RR,   1, 1, 0, 0, 0, 0);
    addRow(0, L_G1R2, 5, 8, 0, 0, 0, 0);
    addRow(0, L_G1R2, 4, 7, 0, 0, 0, 0);
    addRow(0, L_G1R2, 3, 6, 0, 0, 0, 0);
    addRow(0, L_G1R2, 2, 5, 0, 0, 0, 0);
    addRow(0, L_G1R2, 1, 4, 0, 0, 0, 0);
    // night request on the same tick as phase expiry
    addRow(1, L_NY,   0, 0, 1, 0, 0, 0);
    addRow(0, L_RR,   1, 1, 0, 0, 0, 0);
    addRow(0, L_G1R2, 5, 8, 0, 0, 0, 0);
    addRow(0, L_G1R2, 4, 7, 0, 0, 0, 0);
    addRow(0, L_G1R2, 3, 6, 0, 0, 0, 0);
    addRow(0, L_G1R2, 2, 5, 0, 0, 0, 0);
    addRow(0, L_G1R2, 1, 4, 0, 0, 0, 0);
    addRow(0, L_Y1R2, 2, 3, 0, 0, 0, 0);
    addRow(0, L_Y1R2, 1, 2, 0, 0, 0, 0);
    addRow(0, L_RR,   1, 1, 0, 0, 0, 0);
    addRow(0, L_R1G2, 8, 5, 0, 0, 0, 0);
    addRow(0, L_R1G2, 7, 4, 0, 0, 0, 0);
    addRow(0, L_R1G2, 6, 3, 0, 0, 0, 0);
    addRow(0, L_R1G2, 5, 2, 0, 0, 0, 0);
    addRow(0, L_R1G2, 4, 1, 0, 0, 0, 0);
    addRow(0, L_R1Y2, 3, 2, 0, 0, 0, 0);

    rst = 1'b0;
    night_mode = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("reset", L_G1R2, 5, 8, 0);
    compare("reset t12 d1", {bD1Seg1, bD1Seg0}, expSegs(12, 0));
    compare("reset t12 d2", {bD2Seg1, bD2Seg0}, expSegs(15, 0));
    compare("reset t12 lamps", {8'h00, bR1, bY1, bG1, bR2, bY2, bG2}, {8'h00, L_G1R2});
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].night);
      checkOutput($sformatf("row%0d", i + 1), vecs[i].lamps, vecs[i].d1, vecs[i].d2,
                  vecs[i].dark);
      if (vecs[i].chk12) begin
        compare($sformatf("row%0d t12 d1", i + 1), {bD1Seg1, bD1Seg0}, expSegs(vecs[i].d1b, 0));
        compare($sformatf("row%0d t12 d2", i + 1), {bD2Seg1, bD2Seg0}, expSegs(vecs[i].d2b, 0));
      end
    end

    // asynchronous reset in R1Y2, between clock edges
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset", L_G1R2, 5, 8, 0);
    repeat (3) @(negedge clock);
    rst = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("pre first tick", L_G1R2, 5, 8, 0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("first tick", L_G1R2, 4, 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
